// File: rtl/layer_scheduler_if.sv
// Bus between the layer scheduler and its neighbours: layer control, shared-neuron handshake,
// result buffer write port and, with LAYER_SCHEDULER_ARGMAX_EN, the argmax result.
interface layer_scheduler_if #(
  parameter int OUT_SIZE  = 10,
  parameter int WIDTH_OUT = 24
);
  localparam int RW = $clog2(OUT_SIZE);

  // Layer control
  logic                        start;
  logic                        busy;
  logic                        done;

  // Shared neuron: neuron_go is a one-cycle request for row_sel. The neuron has no ready;
  // it answers with a one-cycle neuron_done carrying neuron_value, which only counts
  // while the scheduler is waiting for it.
  logic                        neuron_go;
  logic                        neuron_done;
  logic signed [WIDTH_OUT-1:0] neuron_value;
  logic [RW-1:0]               row_sel;

  // Result buffer write port
  logic                        res_we;
  logic [RW-1:0]               res_addr;
  logic [WIDTH_OUT-1:0]        res_data;

  // Scheduler state, for checkers and debug
  logic [2:0]                  dbg_state;

`ifdef LAYER_SCHEDULER_ARGMAX_EN
  logic [RW-1:0]               argmax;
  logic                        argmax_valid;
`endif

  modport master (
    input  start, neuron_done, neuron_value,
    output busy, done, neuron_go, row_sel, res_we, res_addr, res_data, dbg_state
`ifdef LAYER_SCHEDULER_ARGMAX_EN
    , output argmax, argmax_valid
`endif
  );

  modport slave (
    output start, neuron_done, neuron_value,
    input  busy, done, neuron_go, row_sel, res_we, res_addr, res_data, dbg_state
`ifdef LAYER_SCHEDULER_ARGMAX_EN
    , input argmax, argmax_valid
`endif
  );
endinterface

// File: rtl/layer_scheduler.sv
// Sequences one dense layer through a single shared neuron, one output row at a time,
// writing ReLU results to a buffer. Optional argmax tracking: LAYER_SCHEDULER_ARGMAX_EN.
module layer_scheduler #(
  parameter int OUT_SIZE  = 10,
  parameter int WIDTH_OUT = 24
) (
  input logic              clk,
  input logic              reset,
  layer_scheduler_if.master bus
);
  localparam int RW = $clog2(OUT_SIZE);
  localparam logic [RW-1:0] LAST_ROW = RW'(OUT_SIZE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [RW-1:0]               row_q, row_d;
  logic signed [WIDTH_OUT-1:0] val_q, val_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    val_d   = val_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.neuron_done) begin
          val_d   = bus.neuron_value;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        // The row index stops at the last row; only a fresh start rewinds it.
        if (row_q == LAST_ROW) begin
          state_d = S_FINISH;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = S_ISSUE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      val_q   <= val_d;
    end
  end

  // All outputs are decoded from registered state, so none of them depends combinationally on inputs.
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FINISH);
  assign bus.neuron_go = (state_q == S_ISSUE);
  assign bus.row_sel   = row_q;
  assign bus.res_we    = (state_q == S_STORE);
  assign bus.res_addr  = row_q;
  assign bus.res_data  = ((state_q == S_STORE) && !val_q[WIDTH_OUT-1]) ? val_q : '0;
  assign bus.dbg_state = state_q;

`ifdef LAYER_SCHEDULER_ARGMAX_EN
  logic signed [WIDTH_OUT-1:0] max_q, max_d;
  logic [RW-1:0]               arg_q, arg_d;
  logic                        argv_q, argv_d;

  always_comb begin
    max_d  = max_q;
    arg_d  = arg_q;
    argv_d = argv_q;
    if (state_q == S_IDLE && bus.start) begin
      argv_d = 1'b0;
    end
    // Row 0 seeds the maximum; strict compare keeps the lowest index on ties.
    if (state_q == S_WAIT && bus.neuron_done &&
        (row_q == '0 || bus.neuron_value > max_q)) begin
      max_d = bus.neuron_value;
      arg_d = row_q;
    end
    if (state_q == S_STORE && row_q == LAST_ROW) begin
      argv_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q  <= '0;
      arg_q  <= '0;
      argv_q <= 1'b0;
    end else begin
      max_q  <= max_d;
      arg_q  <= arg_d;
      argv_q <= argv_d;
    end
  end

  assign bus.argmax       = arg_q;
  assign bus.argmax_valid = argv_q;
`endif
endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler with OUT_SIZE=4: the bench plays the shared neuron and
// checks result writes, handshake counts, timing, reset behaviour and optional argmax.
module tb_layer_scheduler;
  localparam int OUT_SIZE = 4;
  localparam int WIDTH    = 24;
  localparam int RW       = 2;
  localparam int W        = RW + WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_scheduler_if #(.OUT_SIZE(OUT_SIZE), .WIDTH_OUT(WIDTH)) bus ();

  layer_scheduler #(.OUT_SIZE(OUT_SIZE), .WIDTH_OUT(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0, go_cnt = 0, done_cnt = 0, go0_cyc = 0, done_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  logic signed [WIDTH-1:0] vals[4];
  logic [WIDTH-1:0]        exp_data[4];

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.res_we === 1'b1) got_q.push_back({bus.res_addr, bus.res_data});
    if (bus.neuron_go === 1'b1) begin
      go_cnt = go_cnt + 1;
      if (bus.row_sel == 2'd0) go0_cyc = cyc;
    end
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_case(input logic signed [WIDTH-1:0] a, b, c, d,
                          input logic [WIDTH-1:0] ea, eb, ec, ed);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    exp_data[0] = ea; exp_data[1] = eb; exp_data[2] = ec; exp_data[3] = ed;
  endtask

  task automatic clear_mon();
    @(negedge clk); #1;
    got_q.delete();
    exp_q.delete();
    go_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic check_writes(input int n);
    logic [W-1:0] e, g;
    n_cmp++;
    if (got_q.size() != n) begin
      n_bad++;
      $display("FAIL write_count: got %0d writes, required %0d", got_q.size(), n);
    end
    for (int i = 0; i < n; i++) exp_q.push_back({2'(i), exp_data[i]});
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL res_write: got addr %0d data %0d, required addr %0d data %0d",
                 g[W-1:WIDTH], g[WIDTH-1:0], e[W-1:WIDTH], e[WIDTH-1:0]);
      end
    end
  endtask

  // Neuron driver: waits for neuron_go of row r, answers after lat WAIT cycles.
  // Returns at the falling edge of the cycle after STORE.
  task automatic serve_row(input int r, input int lat, input bit stray, output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    while (bus.neuron_go !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.neuron_go !== 1'b1) begin
      n_bad++;
      $display("FAIL go_timeout row %0d: neuron_go=%b, required 1", r, bus.neuron_go);
      return;
    end
    n_cmp++;
    if (bus.row_sel !== 2'(r)) begin
      n_bad++;
      $display("FAIL row_sel_issue: got %0d, required %0d", bus.row_sel, r);
    end
    if (stray) begin
      bus.neuron_done  = 1'b1;
      bus.neuron_value = -24'sd777;
    end
    @(negedge clk);
    bus.neuron_done = 1'b0;
    repeat (lat - 1) @(negedge clk);
    bus.neuron_done  = 1'b1;
    bus.neuron_value = vals[r];
    @(negedge clk);
    n_cmp++;
    if (bus.res_we !== 1'b1 || bus.row_sel !== 2'(r)) begin
      n_bad++;
      $display("FAIL store_row: res_we=%b row_sel=%0d, required 1 and %0d", bus.res_we, bus.row_sel, r);
    end
    if (stray) begin
      bus.neuron_done  = 1'b1;
      bus.neuron_value = -24'sd555;
    end else begin
      bus.neuron_done = 1'b0;
    end
    @(negedge clk);
    bus.neuron_done = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_layer(input int lat, input bit hold, input bit stray, input int exp_arg);
    bit ok;
    clear_mon();
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
`ifdef LAYER_SCHEDULER_ARGMAX_EN
    n_cmp++;
    if (bus.argmax_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL argmax_valid_clear: got %b, required 0", bus.argmax_valid);
    end
`endif
    for (int r = 0; r < OUT_SIZE; r++) begin
      serve_row(r, lat, stray, ok);
      if (!ok) begin
        bus.start = 1'b0;
        return;
      end
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL finish: done=%b busy=%b, required 1 1", bus.done, bus.busy);
    end
`ifdef LAYER_SCHEDULER_ARGMAX_EN
    n_cmp++;
    if (bus.argmax_valid !== 1'b1 || bus.argmax !== 2'(exp_arg)) begin
      n_bad++;
      $display("FAIL argmax: valid=%b idx=%0d, required 1 %0d", bus.argmax_valid, bus.argmax, exp_arg);
    end
`endif
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (go_cnt != OUT_SIZE || done_cnt != 1) begin
      n_bad++;
      $display("FAIL pulse_count: go=%0d done=%0d, required %0d 1", go_cnt, done_cnt, OUT_SIZE);
    end
    n_cmp++;
    if (done_cyc - go0_cyc != OUT_SIZE * (lat + 2)) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, required %0d", done_cyc - go0_cyc, OUT_SIZE * (lat + 2));
    end
`ifdef LAYER_SCHEDULER_ARGMAX_EN
    n_cmp++;
    if (bus.argmax_valid !== 1'b1 || bus.argmax !== 2'(exp_arg)) begin
      n_bad++;
      $display("FAIL argmax_hold: valid=%b idx=%0d, required 1 %0d", bus.argmax_valid, bus.argmax, exp_arg);
    end
`endif
    check_writes(OUT_SIZE);
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.neuron_done  = 1'b0;
    bus.neuron_value = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.neuron_go !== 1'b0 || bus.res_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy=%b done=%b go=%b we=%b, required 0000",
               bus.busy, bus.done, bus.neuron_go, bus.res_we);
    end
    n_cmp++;
    if (bus.row_sel !== 2'd0 || bus.res_addr !== 2'd0 || bus.res_data !== 24'd0 || bus.dbg_state !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_data: row_sel=%0d addr=%0d data=%0d state=%0d, required 0",
               bus.row_sel, bus.res_addr, bus.res_data, bus.dbg_state);
    end
`ifdef LAYER_SCHEDULER_ARGMAX_EN
    n_cmp++;
    if (bus.argmax !== 2'd0 || bus.argmax_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_argmax: idx=%0d valid=%b, required 0 0", bus.argmax, bus.argmax_valid);
    end
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    set_case(24'sd5, -24'sd3, 24'sd7, 24'sd0, 24'd5, 24'd0, 24'd7, 24'd0);
    run_layer(2, 1'b0, 1'b0, 2);
  endtask

  task automatic test_latency();
    set_case(24'sd5, -24'sd3, 24'sd7, 24'sd0, 24'd5, 24'd0, 24'd7, 24'd0);
    run_layer(1, 1'b0, 1'b0, 2);
    run_layer(200, 1'b0, 1'b0, 2);
  endtask

  task automatic test_start_held_stray();
    set_case(24'sd100, 24'sd8388607, -24'sd8388608, 24'sd1, 24'd100, 24'd8388607, 24'd0, 24'd1);
    run_layer(3, 1'b1, 1'b1, 1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    set_case(24'sd5, -24'sd3, 24'sd7, 24'sd0, 24'd5, 24'd0, 24'd7, 24'd0);
    clear_mon();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    serve_row(0, 3, 1'b0, ok);
    serve_row(1, 3, 1'b0, ok);
    t = 0;
    while (bus.neuron_go !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.dbg_state !== 3'd2 || bus.row_sel !== 2'd2) begin
      n_bad++;
      $display("FAIL pre_reset: state=%0d row=%0d, required 2 2", bus.dbg_state, bus.row_sel);
    end
    reset            = 1'b1;
    bus.start        = 1'b1;
    bus.neuron_done  = 1'b1;
    bus.neuron_value = 24'sd99;
    @(negedge clk);
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.neuron_done = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.res_we !== 1'b0 || bus.row_sel !== 2'd0 || bus.dbg_state !== 3'd0) begin
      n_bad++;
      $display("FAIL abort: busy=%b we=%b row=%0d state=%0d, required 0 0 0 0",
               bus.busy, bus.res_we, bus.row_sel, bus.dbg_state);
    end
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (done_cnt != 0) begin
      n_bad++;
      $display("FAIL abort_done: got %0d done pulses, required 0", done_cnt);
    end
    check_writes(2);
    run_layer(2, 1'b0, 1'b0, 2);
  endtask

  task automatic test_ties();
    set_case(24'sd9, 24'sd9, -24'sd1, 24'sd9, 24'd9, 24'd9, 24'd0, 24'd9);
    run_layer(2, 1'b0, 1'b0, 0);
  endtask

  task automatic test_all_negative();
    set_case(-24'sd5, -24'sd2, -24'sd8, -24'sd3, 24'd0, 24'd0, 24'd0, 24'd0);
    run_layer(1, 1'b0, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    set_case(24'sd1, 24'sd2, 24'sd3, 24'sd4, 24'd1, 24'd2, 24'd3, 24'd4);
    run_layer(1, 1'b0, 1'b0, 3);
    set_case(24'sd40, -24'sd2, 24'sd30, 24'sd41, 24'd40, 24'd0, 24'd30, 24'd41);
    run_layer(2, 1'b0, 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_start_held_stray();
    test_reset_mid();
    test_ties();
    test_all_negative();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
